sec_counter: RTL
================

// Module: sec_counter
// PURPOSE
// - Time-keeping datapath driven by the stopwatch control FSM's en[1:0] code.
// - Divides clk down to a 1 Hz tick and advances a BCD MM:SS count.
// - Clears, runs or holds the count according to en.
// - Sits between the control FSM and the 7-segment display driver; holds all
//   of the stopwatch's counting state.
// PARAMETERS
// - CLK_DIV  50_000_000  clk cycles per counted second (>=2); benches use 4
// - PRESC_W  26          prescaler width; must satisfy 2**PRESC_W >= CLK_DIV
// PORTS
// - clk       in   1  single system clock, rising edge
// - reset     in   1  asynchronous, active-high reset
// - en        in   2  control code: 2'b00 clear, 2'b01 run, 2'b10 hold; 2'b11 acts as 2'b00
// - sec_ones  out  4  BCD seconds units, 0..9
// - sec_tens  out  4  BCD seconds tens, 0..5
// - min_ones  out  4  BCD minutes units, 0..9
// - min_tens  out  4  BCD minutes tens, 0..5
// - tick      out  1  one-cycle pulse on the clk cycle the count advances
// - wrap      out  1  one-cycle pulse when the count rolls over 59:59 -> 00:00
// - running   out  1  registered copy of (en==2'b01)
// BEHAVIOUR
// - Reset: asynchronous, active-high. Prescaler and all digits go to 0;
//   tick, wrap and running go to 0. No clock edge is needed for this.
// - All outputs are registered. en is sampled on each rising clk edge.
// - en=00 or 11 (CLEAR):
//   - Next edge: prescaler, all digits, tick and wrap go to 0.
//   - Count stays 00:00 for as long as CLEAR is held.
// - en=01 (RUN):
//   - Prescaler increments by 1 per edge.
//   - When prescaler == CLK_DIV-1 on an edge: prescaler goes to 0, the BCD
//     chain increments once, and tick=1 for that one cycle.
//   - First tick comes exactly CLK_DIV edges after RUN starts from a cleared state.
// - en=10 (HOLD):
//   - Prescaler and digits are frozen; tick and wrap are 0.
//   - On return to RUN, counting resumes from the frozen prescaler value, so
//     the fractional second is kept (no re-phasing).
// - BCD chain, per tick:
//   - sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones.
//   - min_ones 9->0 carries into min_tens; min_tens 5->0 at 59:59 gives 00:00
//     and wrap=1 for the same cycle as tick.
//   - Digits never take values outside their stated ranges.
// - Simultaneous events:
//   - CLEAR on the terminal-count edge: CLEAR wins; no tick, no wrap.
//   - HOLD on the terminal-count edge: no tick; prescaler stays at CLK_DIV-1,
//     and the tick fires on the first RUN edge after HOLD.
// - running = 1 exactly while the sampled en == 01; updates one edge after en.
// - Reset mid-count overrides everything. After reset deassertion, behaviour
//   is as from a cleared state.
// TESTING (CLK_DIV=4 unless noted)
// 1. Hold reset, then release with en=01 -> tick on edges 4, 8, 12;
//    sec_ones=1,2,3; running=1 one edge after en.
// 2. RUN 2 edges, HOLD 10 edges, RUN -> digits frozen during HOLD; first
//    tick on the 2nd RUN edge after HOLD.
// 3. Preload by running to 00:09 then 00:59 -> next tick gives 00:10, then
//    01:00; sec_tens never shows 6.
// 4. Run to 59:59 (CLK_DIV=2 to shorten) -> next tick gives 00:00 with tick=1
//    and wrap=1 for one cycle only.
// 5. At 00:07 drive en=00, then repeat with en=11 -> all digits 0 on the next
//    edge and held at 0; no tick.
// 6. Assert reset asynchronously between edges at 03:41 -> outputs 0 before
//    the next clk edge. Also drive en 01->10 exactly on the terminal-count
//    edge -> no tick until RUN returns.

Source files
------------

// File: rtl/sec_counter.sv
// Stopwatch time base: divides clk to a 1 Hz tick and keeps a BCD MM:SS count.
// The count is cleared, run or held according to the control FSM's en code.
module sec_counter #(
    parameter int CLK_DIV = 50_000_000,
    parameter int PRESC_W = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    typedef enum logic [1:0] {
        MODE_CLEAR,
        MODE_RUN,
        MODE_HOLD
    } mode_t;

    localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    mode_t              mode;
    logic               terminal;
    logic               c_sec_ones;
    logic               c_sec_tens;
    logic               c_min_ones;
    logic               at_max;
    logic [3:0]         nxt_sec_ones;
    logic [3:0]         nxt_sec_tens;
    logic [3:0]         nxt_min_ones;
    logic [3:0]         nxt_min_tens;

    // 2'b11 is not a defined command, so it falls back to CLEAR.
    always_comb begin
        unique case (en)
            2'b01:   mode = MODE_RUN;
            2'b10:   mode = MODE_HOLD;
            default: mode = MODE_CLEAR;
        endcase
    end

    assign terminal = (presc == TERM);

    // Each digit rolls at or above its limit so it can never leave its range.
    always_comb begin
        c_sec_ones   = (sec_ones >= 4'd9);
        c_sec_tens   = c_sec_ones && (sec_tens >= 4'd5);
        c_min_ones   = c_sec_tens && (min_ones >= 4'd9);
        at_max       = c_min_ones && (min_tens >= 4'd5);

        nxt_sec_ones = c_sec_ones ? '0 : sec_ones + 4'd1;
        nxt_sec_tens = sec_tens;
        nxt_min_ones = min_ones;
        nxt_min_tens = min_tens;
        if (c_sec_ones) begin
            nxt_sec_tens = c_sec_tens ? '0 : sec_tens + 4'd1;
        end
        if (c_sec_tens) begin
            nxt_min_ones = c_min_ones ? '0 : min_ones + 4'd1;
        end
        if (c_min_ones) begin
            nxt_min_tens = at_max ? '0 : min_tens + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            running  <= 1'b0;
        end else begin
            running <= (mode == MODE_RUN);
            tick    <= 1'b0;
            wrap    <= 1'b0;
            unique case (mode)
                MODE_RUN: begin
                    if (terminal) begin
                        presc    <= '0;
                        sec_ones <= nxt_sec_ones;
                        sec_tens <= nxt_sec_tens;
                        min_ones <= nxt_min_ones;
                        min_tens <= nxt_min_tens;
                        tick     <= 1'b1;
                        wrap     <= at_max;
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
                // Prescaler is frozen too, so the partial second survives a hold.
                MODE_HOLD: begin
                end
                default: begin
                    presc    <= '0;
                    sec_ones <= '0;
                    sec_tens <= '0;
                    min_ones <= '0;
                    min_tens <= '0;
                end
            endcase
        end
    end

endmodule
